// File: rtl/adc_sync_monitor_nch_if.sv
// adc_sync_monitor_nch_if: sample bus, check control and result signals of the sync monitor
interface adc_sync_monitor_nch_if #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int LANES_PER_CH = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_CH*LANES_PER_CH*ADC_DATA_WIDTH-1:0] adc_data_i;
  logic [1:0] mode_i;
  logic [CNT_WIDTH-1:0] window_len_i;
  logic start_i;
  logic busy_o;
  logic done_o;
  logic sync_ok_o;
  logic [CNT_WIDTH-1:0] mismatch_cnt_o;
  logic [$clog2(NUM_CH)-1:0] first_fail_o;
  modport master (
    output adc_data_i, mode_i, window_len_i, start_i,
    input busy_o, done_o, sync_ok_o, mismatch_cnt_o, first_fail_o
  );
  modport slave (
    input adc_data_i, mode_i, window_len_i, start_i,
    output busy_o, done_o, sync_ok_o, mismatch_cnt_o, first_fail_o
  );
endinterface

// File: rtl/adc_sync_monitor_nch.sv
// adc_sync_monitor_nch: windowed N-channel ADC lane alignment checker
module adc_sync_monitor_nch #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int LANES_PER_CH = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  adc_sync_monitor_nch_if.slave bus
);
  localparam int W = ADC_DATA_WIDTH;
  localparam int CW = ADC_DATA_WIDTH * LANES_PER_CH;
  localparam int FW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;
  state_t st;
  logic [NUM_CH*CW-1:0] s1;
  logic [NUM_CH-1:0] mv, mv_q;
  logic [W-1:0] lane0 [NUM_CH];
  logic [W-1:0] ch0_l1;
  logic [1:0] mode_q;
  logic [CNT_WIDTH-1:0] len_q, wcnt, mcnt, wcnt_nx, mcnt_nx;
  logic flush_q, seen_q, fail;
  logic [FW-1:0] low_idx, ff_q, ff_nx;
  logic unused_lanes;
  assign unused_lanes = ^s1;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) lane0[c] = s1[c*CW +: W];
    ch0_l1 = s1[W +: W];
    mv = '1;
    mv[1] = (mode_q == 2'd0) ? lane0[1] == lane0[0] : ch0_l1 == lane0[1];
    for (int c = 2; c < NUM_CH; c++)
      mv[c] = lane0[c] == ((mode_q == 2'd1) ? lane0[c-2] : (mode_q == 2'd2) ? lane0[1] : lane0[0]);
  end
  always_comb begin
    low_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) if (!mv_q[c]) low_idx = FW'(c);
  end
  assign fail = ~&mv_q;
  assign wcnt_nx = wcnt + CNT_WIDTH'(1);
  assign mcnt_nx = (fail && ~&mcnt) ? mcnt + CNT_WIDTH'(1) : mcnt;
  assign ff_nx = (fail && !seen_q) ? low_idx : ff_q;
  always_ff @(posedge clk) begin
    s1 <= bus.adc_data_i;
    mv_q <= mv;
    if (rst) begin
      st <= IDLE;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.sync_ok_o <= 1'b0;
      bus.mismatch_cnt_o <= '0;
      bus.first_fail_o <= '0;
      mode_q <= 2'd0;
      len_q <= '0;
      wcnt <= '0;
      mcnt <= '0;
      ff_q <= '0;
      seen_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (st)
        IDLE: if (bus.start_i) begin
          st <= FLUSH;
          bus.busy_o <= 1'b1;
          mode_q <= (bus.mode_i == 2'd3) ? 2'd0 : bus.mode_i;
          len_q <= (bus.window_len_i == '0) ? CNT_WIDTH'(1) : bus.window_len_i;
          wcnt <= '0;
          mcnt <= '0;
          ff_q <= '0;
          seen_q <= 1'b0;
          flush_q <= 1'b0;
        end
        FLUSH: begin
          flush_q <= 1'b1;
          st <= flush_q ? RUN : FLUSH;
        end
        RUN: begin
          wcnt <= wcnt_nx;
          mcnt <= mcnt_nx;
          ff_q <= ff_nx;
          seen_q <= seen_q | fail;
          if (wcnt_nx == len_q) begin
            st <= DONE;
            bus.done_o <= 1'b1;
            bus.sync_ok_o <= mcnt_nx == '0;
            bus.mismatch_cnt_o <= mcnt_nx;
            bus.first_fail_o <= ff_nx;
          end
        end
        default: begin
          st <= IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_sync_monitor_nch.sv
// tb_adc_sync_monitor_nch: directed checks of the N-channel ADC sync monitor
module tb_adc_sync_monitor_nch;
  logic clk, rst;
  int errors = 0, checks = 0, lat, xd, nd;
  logic [255:0] base;
  adc_sync_monitor_nch_if if0 ();
  adc_sync_monitor_nch_if #(.CNT_WIDTH(4)) if1 ();
  adc_sync_monitor_nch u0 (.clk(clk), .rst(rst), .bus(if0));
  adc_sync_monitor_nch #(.CNT_WIDTH(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [255:0] put(input logic [255:0] v, input int ch, input int lane, input logic [7:0] x);
    v[ch*64 + lane*8 +: 8] = x;
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic reset_chk(input string tag);
    chk({tag, "_busy"}, 32'(if0.busy_o), 0);
    chk({tag, "_done"}, 32'(if0.done_o), 0);
    chk({tag, "_ok"}, 32'(if0.sync_ok_o), 0);
    chk({tag, "_cnt"}, 32'(if0.mismatch_cnt_o), 0);
    chk({tag, "_ff"}, 32'(if0.first_fail_o), 0);
  endtask
  task automatic run(input logic [1:0] m, input logic [15:0] len, input int bfrom, input int bto,
                     input int bch, input int blane, input logic [7:0] bval, input int extra,
                     input bit poke, output int lat_o, output int xd_o);
    lat_o = -1;
    xd_o = 0;
    @(posedge clk); #1;
    if0.mode_i = m;
    if0.window_len_i = len;
    if0.start_i = 1'b1;
    if0.adc_data_i = (bfrom <= 0 && bto >= 0) ? put(base, bch, blane, bval) : base;
    for (int n = 1; n <= 300 && lat_o < 0; n++) begin
      @(posedge clk); #1;
      if0.mode_i = m + 2'd1;
      if0.window_len_i = 16'd3;
      if0.start_i = (n == extra);
      if0.adc_data_i = (n >= bfrom && n <= bto) ? put(base, bch, blane, bval) : base;
      if (if0.done_o) begin
        lat_o = n;
        if0.start_i = poke;
      end
    end
    @(posedge clk); #1;
    if0.start_i = 1'b0;
    if0.adc_data_i = base;
    for (int n = 0; n < 8; n++) begin
      xd_o += int'(if0.done_o);
      @(posedge clk); #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    base = '0;
    if0.adc_data_i = '0;
    if0.mode_i = 2'd0;
    if0.window_len_i = '0;
    if0.start_i = 1'b0;
    if1.adc_data_i = put(256'd0, 1, 0, 8'h01);
    if1.mode_i = 2'd0;
    if1.window_len_i = 4'd15;
    if1.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("rst_init");
    rst = 1'b0;
    // T1: constant aligned data, mode 0
    for (int c = 0; c < 4; c++) base = put(base, c, 0, 8'h5A);
    run(2'd0, 16'd16, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t1_lat", 32'(lat), 19);
    chk("t1_ok", 32'(if0.sync_ok_o), 1);
    chk("t1_cnt", 32'(if0.mismatch_cnt_o), 0);
    chk("t1_ff", 32'(if0.first_fail_o), 0);
    chk("t1_busy", 32'(if0.busy_o), 0);
    chk("t1_xdone", 32'(xd), 0);
    // T2: glitches inside and outside the compared window
    run(2'd0, 16'd16, 5, 7, 2, 0, 8'h5B, 0, 1'b0, lat, xd);
    chk("t2_ok", 32'(if0.sync_ok_o), 0);
    chk("t2_cnt", 32'(if0.mismatch_cnt_o), 3);
    chk("t2_ff", 32'(if0.first_fail_o), 2);
    run(2'd0, 16'd16, 0, 0, 2, 0, 8'h5B, 0, 1'b0, lat, xd);
    chk("t2_pre_ok", 32'(if0.sync_ok_o), 1);
    run(2'd0, 16'd16, 17, 19, 2, 0, 8'h5B, 0, 1'b0, lat, xd);
    chk("t2_post_cnt", 32'(if0.mismatch_cnt_o), 0);
    run(2'd0, 16'd16, 16, 16, 3, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t2_last_cnt", 32'(if0.mismatch_cnt_o), 1);
    chk("t2_last_ff", 32'(if0.first_fail_o), 3);
    // T3: full interleave, then mode 3 falls back to parallel rule
    base = '0;
    base = put(base, 0, 1, 8'h33);
    for (int c = 1; c < 4; c++) base = put(base, c, 0, 8'h33);
    run(2'd2, 16'd5, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t3_ok", 32'(if0.sync_ok_o), 1);
    chk("t3_lat", 32'(lat), 8);
    run(2'd3, 16'd5, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t3_m3_cnt", 32'(if0.mismatch_cnt_o), 5);
    chk("t3_m3_ff", 32'(if0.first_fail_o), 1);
    base = put(base, 0, 1, 8'h34);
    run(2'd2, 16'd5, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t3_bad_ok", 32'(if0.sync_ok_o), 0);
    chk("t3_bad_cnt", 32'(if0.mismatch_cnt_o), 5);
    chk("t3_bad_ff", 32'(if0.first_fail_o), 1);
    // T4: dual interleave
    base = '0;
    base = put(base, 0, 0, 8'h11);
    base = put(base, 2, 0, 8'h11);
    base = put(base, 1, 0, 8'h22);
    base = put(base, 3, 0, 8'h22);
    base = put(base, 0, 1, 8'h22);
    run(2'd1, 16'd6, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t4_ok", 32'(if0.sync_ok_o), 1);
    run(2'd1, 16'd6, 2, 2, 0, 1, 8'h00, 0, 1'b0, lat, xd);
    chk("t4_l1_cnt", 32'(if0.mismatch_cnt_o), 1);
    chk("t4_l1_ff", 32'(if0.first_fail_o), 1);
    base = put(base, 3, 0, 8'h23);
    run(2'd1, 16'd6, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t4_ch3_cnt", 32'(if0.mismatch_cnt_o), 6);
    chk("t4_ch3_ff", 32'(if0.first_fail_o), 3);
    // T5: zero length, start while busy and in the done cycle
    base = '0;
    for (int c = 0; c < 4; c++) base = put(base, c, 0, 8'h5A);
    run(2'd0, 16'd0, 1, 0, 0, 0, 8'h00, 2, 1'b1, lat, xd);
    chk("t5_lat", 32'(lat), 4);
    chk("t5_xdone", 32'(xd), 0);
    chk("t5_ok", 32'(if0.sync_ok_o), 1);
    run(2'd0, 16'd0, 1, 1, 1, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t5_one_cnt", 32'(if0.mismatch_cnt_o), 1);
    chk("t5_one_ff", 32'(if0.first_fail_o), 1);
    // saturation on the narrow-counter instance
    @(posedge clk); #1;
    if1.start_i = 1'b1;
    @(posedge clk); #1;
    if1.start_i = 1'b0;
    lat = -1;
    for (int n = 2; n <= 100 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (if1.done_o) lat = n;
    end
    chk("t5_sat_lat", 32'(lat), 18);
    chk("t5_sat_cnt", 32'(if1.mismatch_cnt_o), 32'hF);
    chk("t5_sat_ok", 32'(if1.sync_ok_o), 0);
    chk("t5_sat_ff", 32'(if1.first_fail_o), 1);
    // T6: reset in the middle of a window
    @(posedge clk); #1;
    if0.mode_i = 2'd0;
    if0.window_len_i = 16'd16;
    if0.start_i = 1'b1;
    @(posedge clk); #1;
    if0.start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6_busy_pre", 32'(if0.busy_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_chk("t6_rst");
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      nd += int'(if0.done_o);
    end
    chk("t6_nodone", 32'(nd), 0);
    run(2'd0, 16'd16, 1, 0, 0, 0, 8'h00, 0, 1'b0, lat, xd);
    chk("t6_lat", 32'(lat), 19);
    chk("t6_ok", 32'(if0.sync_ok_o), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
